// File: rtl/booth_radix4_acc.sv
// Radix-4 Booth partial-product accumulator: sums N_PP encoded digits into a signed product.
// Latency: res_valid_o rises the cycle after the last beat is accepted; minimum N_PP+1 cycles per product.
// Backpressure: pp_ready_o drops while a product waits in DONE; no new beat until res_ready_i releases it.
module booth_radix4_acc #(
    parameter int DATA_W = 8,
    parameter int N_PP   = 4,
    parameter int RES_W  = 16,
    localparam int IDX_W = (N_PP > 1) ? $clog2(N_PP) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pp_valid_i,
    output logic              pp_ready_o,
    input  logic [DATA_W:0]   pp_res_i,
    input  logic              pp_sign_i,
    input  logic              pp_ext_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [RES_W-1:0]  res_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PP - 1);

    state_t             state_q;
    state_t             state_d;
    logic [RES_W-1:0]   acc_q;
    logic [IDX_W-1:0]   idx_q;
    logic [RES_W-1:0]   res_q;
    logic               res_vld_q;
    logic               err_q;

    logic               pp_beat;
    logic               last_beat;
    logic               ext_mismatch;
    logic [RES_W-1:0]   term_base;
    logic [RES_W-1:0]   term_shift;
    logic [RES_W-1:0]   acc_base;
    logic [RES_W-1:0]   acc_sum;

    // Next-state and handshake decode; pp_ready_o depends on state alone.
    always_comb begin
        state_d    = state_q;
        pp_ready_o = (state_q != DONE);
        pp_beat    = pp_valid_i & pp_ready_o;
        last_beat  = pp_beat && (idx_q == LAST_IDX);

        case (state_q)
            IDLE: begin
                if (pp_beat) begin
                    state_d = last_beat ? DONE : ACC;
                end
            end
            ACC: begin
                if (last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The extension bit replaces the MSB of the encoded word, so a mismatch
    // is flagged but the arithmetic still follows pp_ext_i.
    always_comb begin
        term_base    = {{(RES_W - DATA_W){pp_ext_i}}, pp_res_i[DATA_W-1:0]}
                     + RES_W'(pp_sign_i);
        term_shift   = term_base << {idx_q, 1'b0};
        acc_base     = (state_q == IDLE) ? '0 : acc_q;
        acc_sum      = acc_base + term_shift;
        ext_mismatch = (pp_ext_i != pp_res_i[DATA_W]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            idx_q     <= '0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;

            if (pp_beat) begin
                acc_q <= acc_sum;
                idx_q <= last_beat ? '0 : idx_q + IDX_W'(1);
                if (ext_mismatch) begin
                    err_q <= 1'b1;
                end
            end

            if (last_beat) begin
                res_q     <= acc_sum;
                res_vld_q <= 1'b1;
            end else if ((state_q == DONE) && res_ready_i) begin
                res_vld_q <= 1'b0;
            end
        end
    end

    assign res_o       = res_q;
    assign res_valid_o = res_vld_q;
    assign idx_o       = idx_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_booth_radix4_acc.sv
// Directed and randomized checks of booth_radix4_acc against an arithmetic reference (a*b and weighted digit sums).
module tb_booth_radix4_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        pp_valid_i;
    logic        pp_ready_o;
    logic [8:0]  pp_res_i;
    logic        pp_sign_i;
    logic        pp_ext_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [15:0] res_o;
    logic [1:0]  idx_o;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] b_res [4];
    logic       b_sign[4];
    logic       b_ext [4];

    booth_radix4_acc #(.DATA_W(8), .N_PP(4), .RES_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .pp_valid_i  (pp_valid_i),
        .pp_ready_o  (pp_ready_o),
        .pp_res_i    (pp_res_i),
        .pp_sign_i   (pp_sign_i),
        .pp_ext_i    (pp_ext_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_o       (res_o),
        .idx_o       (idx_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_beat(input int i, input logic [8:0] r, input logic s, input logic e);
        b_res[i]  = r;
        b_sign[i] = s;
        b_ext[i]  = e;
    endtask

    // Radix-4 Booth recoding of b, partial products d*a, LSB digit first.
    task automatic load_booth(input logic [7:0] a, input logic [7:0] b);
        logic [8:0]  bx;
        logic [31:0] pv;
        int d;
        int p;
        bx = {b, 1'b0};
        for (int i = 0; i < 4; i++) begin
            d  = -2 * int'(bx[2*i+2]) + int'(bx[2*i+1]) + int'(bx[2*i]);
            p  = ((d < 0) ? -d : d) * int'($signed(a));
            pv = p;
            if (d < 0) set_beat(i, ~pv[8:0], 1'b1, ~pv[8]);
            else       set_beat(i, pv[8:0], 1'b0, pv[8]);
        end
    endtask

    function automatic logic [15:0] model_sum();
        int acc = 0;
        int v;
        logic [31:0] t;
        for (int i = 0; i < 4; i++) begin
            v   = b_ext[i] ? int'(b_res[i][7:0]) - 256 : int'(b_res[i][7:0]);
            acc = acc + ((v + int'(b_sign[i])) * (1 << (2*i)));
        end
        t = acc;
        return t[15:0];
    endfunction

    function automatic logic [15:0] model_mul(input logic [7:0] a, input logic [7:0] b);
        logic [31:0] t;
        t = int'($signed(a)) * int'($signed(b));
        return t[15:0];
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_beat(input int i);
        int t = 0;
        pp_valid_i = 1'b1;
        pp_res_i   = b_res[i];
        pp_sign_i  = b_sign[i];
        pp_ext_i   = b_ext[i];
        while (!pp_ready_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("pp_ready_wait", 32'(pp_ready_o), 32'd1);
        @(negedge clk);
        pp_valid_i = 1'b0;
        pp_res_i   = '0;
        pp_sign_i  = 1'b0;
        pp_ext_i   = 1'b0;
    endtask

    task automatic run_product(input string tag, input logic [15:0] exp, input int gap, input int hold);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_idx"}, 32'(idx_o), 32'(i));
            send_beat(i);
            if (i < 3 && gap > 0) repeat (gap) @(negedge clk);
        end
        check({tag, "_vld"}, 32'(res_valid_o), 32'd1);
        check({tag, "_rdy_done"}, 32'(pp_ready_o), 32'd0);
        check({tag, "_res"}, 32'(res_o), 32'(exp));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_res"}, 32'(res_o), 32'(exp));
            check({tag, "_hold_vld"}, 32'(res_valid_o), 32'd1);
            check({tag, "_hold_rdy"}, 32'(pp_ready_o), 32'd0);
        end
        // Offer a beat during the releasing cycle: it must not be taken.
        res_ready_i = 1'b1;
        pp_valid_i  = 1'b1;
        pp_res_i    = 9'h055;
        @(negedge clk);
        res_ready_i = 1'b0;
        pp_valid_i  = 1'b0;
        pp_res_i    = '0;
        check({tag, "_vld_drop"}, 32'(res_valid_o), 32'd0);
        check({tag, "_rdy_idle"}, 32'(pp_ready_o), 32'd1);
        check({tag, "_no_overlap"}, 32'(idx_o), 32'd0);
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] r;

        rst         = 1'b1;
        pp_valid_i  = 1'b0;
        pp_res_i    = '0;
        pp_sign_i   = 1'b0;
        pp_ext_i    = 1'b0;
        res_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_vld", 32'(res_valid_o), 32'd0);
        check("rst_idx", 32'(idx_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_res", 32'(res_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rdy", 32'(pp_ready_o), 32'd1);

        // 3 x 5
        set_beat(0, 9'h003, 0, 0); set_beat(1, 9'h003, 0, 0);
        set_beat(2, 9'h000, 0, 0); set_beat(3, 9'h000, 0, 0);
        run_product("t1_3x5", 16'h000F, 0, 0);
        check("t1_err", 32'(err_o), 32'd0);

        // -128 x -128
        set_beat(0, 9'h000, 0, 0); set_beat(1, 9'h000, 0, 0);
        set_beat(2, 9'h000, 0, 0); set_beat(3, 9'h0FF, 1, 0);
        run_product("t2_m128sq", 16'h4000, 0, 0);
        load_booth(8'h80, 8'h80);
        check("t2_model", 32'(model_sum()), 32'(model_mul(8'h80, 8'h80)));

        // Negative-zero digits
        for (int i = 0; i < 4; i++) set_beat(i, 9'h1FF, 1, 1);
        run_product("t3_negzero", 16'h0000, 0, 0);

        // Backpressure and gaps
        set_beat(0, 9'h003, 0, 0); set_beat(1, 9'h003, 0, 0);
        set_beat(2, 9'h000, 0, 0); set_beat(3, 9'h000, 0, 0);
        run_product("t4_bp", 16'h000F, 2, 3);
        load_booth(8'd7, 8'hF3);
        run_product("t4_after", model_mul(8'd7, 8'hF3), 0, 0);

        // Reset mid-operation
        set_beat(0, 9'h000, 0, 0); set_beat(1, 9'h000, 0, 0);
        set_beat(2, 9'h000, 0, 0); set_beat(3, 9'h0FF, 1, 0);
        send_beat(0);
        send_beat(1);
        check("t5_idx_mid", 32'(idx_o), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_idx_rst", 32'(idx_o), 32'd0);
        check("t5_rdy_rst", 32'(pp_ready_o), 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t5_no_vld", 32'(res_valid_o), 32'd0);
        end
        set_beat(0, 9'h003, 0, 0); set_beat(1, 9'h003, 0, 0);
        set_beat(2, 9'h000, 0, 0); set_beat(3, 9'h000, 0, 0);
        run_product("t5_rerun", 16'h000F, 0, 0);

        // Extension mismatch on digit 0
        check("t6_err_pre", 32'(err_o), 32'd0);
        set_beat(0, 9'h1F0, 0, 0); set_beat(1, 9'h000, 0, 0);
        set_beat(2, 9'h000, 0, 0); set_beat(3, 9'h000, 0, 0);
        send_beat(0);
        check("t6_err_next", 32'(err_o), 32'd1);
        for (int i = 1; i < 4; i++) send_beat(i);
        check("t6_res", 32'(res_o), 32'h00F0);
        res_ready_i = 1'b1;
        @(negedge clk);
        res_ready_i = 1'b0;
        load_booth(8'hA5, 8'h3C);
        run_product("t6_next", model_mul(8'hA5, 8'h3C), 0, 0);
        check("t6_err_sticky", 32'(err_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_err_clr", 32'(err_o), 32'd0);

        // Random signed products via Booth recoding
        for (int n = 0; n < 25; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            load_booth(a, b);
            run_product("rnd_mul", model_mul(a, b), int'($urandom_range(2, 0)), int'($urandom_range(2, 0)));
        end

        // Random raw beats against the weighted-sum model
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < 4; i++) begin
                r = 9'($urandom);
                set_beat(i, r, 1'($urandom), r[8]);
            end
            run_product("rnd_raw", model_sum(), int'($urandom_range(1, 0)), 0);
        end
        check("rnd_err", 32'(err_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
